// File: rtl/board_ctl.sv
// Tic-tac-toe controller for the 3x3 board: occupancy, turn order, win/draw detection
// and frame-synchronised per-square highlight enables for the draw chain.
module board_ctl #(
  parameter int X0     = 8,
  parameter int Y0     = 3,
  parameter int CELL_W = 336,
  parameter int CELL_H = 256
)(
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        vblnk_in,
  input  logic        new_game,
  output logic [8:0]  square_en,
  output logic [8:0]  board_x,
  output logic [8:0]  board_o,
  output logic        turn,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [11:0] XB0 = 12'(X0);
  localparam logic [11:0] XB1 = 12'(X0 + CELL_W);
  localparam logic [11:0] XB2 = 12'(X0 + 2*CELL_W);
  localparam logic [11:0] XB3 = 12'(X0 + 3*CELL_W);
  localparam logic [11:0] YB0 = 12'(Y0);
  localparam logic [11:0] YB1 = 12'(Y0 + CELL_H);
  localparam logic [11:0] YB2 = 12'(Y0 + 2*CELL_H);
  localparam logic [11:0] YB3 = 12'(Y0 + 3*CELL_H);

  typedef enum logic [2:0] {IDLE, CHECK, PLACE, EVAL, OVER} state_t;

  state_t      state_q;
  logic [3:0]  hover_idx_q, hover_idx_d, click_idx_q;
  logic        hover_vld_q, hover_vld_d, click_vld_q, click_pend_q;
  logic        mouse_q, vblnk_q;
  logic [8:0]  sq_q, sq_d;
  logic [8:0]  board_x_q, board_o_q, occ, mask, mover;
  logic        turn_q, over_q;
  logic [1:0]  winner_q;
  logic [2:0]  cnt_q;
  logic [1:0]  col, row;
  logic [3:0]  row_base;
  logic        click;

  // Cell decode by threshold compares; row*3 comes from a tiny lookup.
  always_comb begin
    col         = 2'd0;
    row         = 2'd0;
    hover_vld_d = 1'b1;
    if (xpos < XB0 || xpos >= XB3) hover_vld_d = 1'b0;
    else if (xpos >= XB2)          col = 2'd2;
    else if (xpos >= XB1)          col = 2'd1;
    if (ypos < YB0 || ypos >= YB3) hover_vld_d = 1'b0;
    else if (ypos >= YB2)          row = 2'd2;
    else if (ypos >= YB1)          row = 2'd1;
    case (row)
      2'd1:    row_base = 4'd3;
      2'd2:    row_base = 4'd6;
      default: row_base = 4'd0;
    endcase
    hover_idx_d = row_base + {2'b00, col};
  end

  assign occ   = board_x_q | board_o_q;
  assign click = mouse_left && !mouse_q;
  assign mover = turn_q ? board_o_q : board_x_q;

  always_comb begin
    case (cnt_q)
      3'd0:    mask = 9'b000_000_111;
      3'd1:    mask = 9'b000_111_000;
      3'd2:    mask = 9'b111_000_000;
      3'd3:    mask = 9'b001_001_001;
      3'd4:    mask = 9'b010_010_010;
      3'd5:    mask = 9'b100_100_100;
      3'd6:    mask = 9'b100_010_001;
      default: mask = 9'b001_010_100;
    endcase
  end

  always_comb begin
    sq_d = 9'd0;
    if (hover_vld_q && !occ[hover_idx_q] && !over_q) sq_d = 9'd1 << hover_idx_q;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hover_idx_q <= 4'd0;
      hover_vld_q <= 1'b0;
      mouse_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      sq_q        <= 9'd0;
    end else begin
      hover_idx_q <= hover_idx_d;
      hover_vld_q <= hover_vld_d;
      mouse_q     <= mouse_left;
      vblnk_q     <= vblnk_in;
      if (new_game)                  sq_q <= 9'd0;
      else if (vblnk_in && !vblnk_q) sq_q <= sq_d;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      click_idx_q  <= 4'd0;
      click_vld_q  <= 1'b0;
      click_pend_q <= 1'b0;
      board_x_q    <= 9'd0;
      board_o_q    <= 9'd0;
      turn_q       <= 1'b0;
      over_q       <= 1'b0;
      winner_q     <= 2'b00;
      cnt_q        <= 3'd0;
    end else if (new_game) begin
      state_q      <= IDLE;
      click_pend_q <= 1'b0;
      board_x_q    <= 9'd0;
      board_o_q    <= 9'd0;
      turn_q       <= 1'b0;
      over_q       <= 1'b0;
      winner_q     <= 2'b00;
      cnt_q        <= 3'd0;
    end else begin
      // One-deep click buffer; CHECK clears it only when it is already full.
      if (click && !click_pend_q) begin
        click_pend_q <= 1'b1;
        click_idx_q  <= hover_idx_q;
        click_vld_q  <= hover_vld_q;
      end
      case (state_q)
        IDLE:  if (click_pend_q) state_q <= CHECK;
        CHECK: begin
          click_pend_q <= 1'b0;
          if (!click_vld_q || occ[click_idx_q]) state_q <= IDLE;
          else                                  state_q <= PLACE;
        end
        PLACE: begin
          if (turn_q) board_o_q[click_idx_q] <= 1'b1;
          else        board_x_q[click_idx_q] <= 1'b1;
          cnt_q   <= 3'd0;
          state_q <= EVAL;
        end
        EVAL: begin
          if ((mover & mask) == mask) begin
            winner_q <= turn_q ? 2'b10 : 2'b01;
            over_q   <= 1'b1;
            state_q  <= OVER;
          end else if (cnt_q == 3'd7) begin
            if (occ == 9'h1FF) begin
              winner_q <= 2'b11;
              over_q   <= 1'b1;
              state_q  <= OVER;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= OVER;
      endcase
    end
  end

  // new_game blanks the highlight in the same cycle it is asserted.
  assign square_en = new_game ? 9'd0 : sq_q;
  assign board_x   = board_x_q;
  assign board_o   = board_o_q;
  assign turn      = turn_q;
  assign busy      = (state_q != IDLE) && (state_q != OVER);
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl: hover decode, highlight timing, move latency, win, draw, abort.
module tb_board_ctl;
  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mouse_left, vblnk_in, new_game;
  logic [8:0]  square_en, board_x, board_o;
  logic        turn, busy, game_over;
  logic [1:0]  winner;
  int          checks = 0;
  int          failures = 0;

  board_ctl dut (
    .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .vblnk_in(vblnk_in), .new_game(new_game), .square_en(square_en),
    .board_x(board_x), .board_o(board_o), .turn(turn), .busy(busy),
    .game_over(game_over), .winner(winner)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves time just after edge E (the edge that samples the click).
  task automatic click_at(input logic [11:0] x, input logic [11:0] y);
    xpos = x; ypos = y; mouse_left = 1'b0;
    tick(); tick();
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
  endtask

  task automatic move(input logic [11:0] x, input logic [11:0] y);
    click_at(x, y);
    repeat (12) tick();
  endtask

  task automatic vpulse();
    vblnk_in = 1'b1; tick();
    vblnk_in = 1'b0; tick();
  endtask

  task automatic pulse_ng();
    new_game = 1'b1; tick();
    new_game = 1'b0;
  endtask

  // Square centres: col x = 100/400/700, row y = 100/300/600.
  initial begin
    rst = 1'b0; xpos = 12'd0; ypos = 12'd0;
    mouse_left = 1'b0; vblnk_in = 1'b0; new_game = 1'b0;
    #1;
    chk("rst_board_x", board_x, 9'd0);
    chk("rst_busy", 9'(busy), 9'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // 1: highlight loads only on a vblnk rising edge
    xpos = 12'd400; ypos = 12'd100; tick(); tick();
    chk("sq_before_vblnk", square_en, 9'h000);
    vblnk_in = 1'b1; tick();
    chk("sq_hover1", square_en, 9'h002);
    xpos = 12'd700; repeat (3) tick();
    vblnk_in = 1'b0; tick();
    chk("sq_hold", square_en, 9'h002);
    xpos = 12'd7; ypos = 12'd100; tick(); vpulse();
    chk("sq_left_of_grid", square_en, 9'h000);
    xpos = 12'd1015; ypos = 12'd770; tick(); vpulse();
    chk("sq_last_pixel", square_en, 9'h100);
    xpos = 12'd1016; tick(); vpulse();
    chk("sq_right_of_grid", square_en, 9'h000);
    xpos = 12'd8; ypos = 12'd3; tick(); vpulse();
    chk("sq_first_pixel", square_en, 9'h001);
    xpos = 12'd344; ypos = 12'd259; tick(); vpulse();
    chk("sq_cell_boundary", square_en, 9'h010);

    // 2: move latency
    click_at(12'd100, 12'd100);
    chk("e0_busy", 9'(busy), 9'd0);
    tick(); chk("e1_busy", 9'(busy), 9'd1);
    tick(); chk("e2_board_x", board_x, 9'h000);
    tick(); chk("e3_board_x", board_x, 9'h001);
    repeat (7) tick();
    chk("e10_busy", 9'(busy), 9'd1);
    chk("e10_turn", 9'(turn), 9'd0);
    tick();
    chk("e11_turn", 9'(turn), 9'd1);
    chk("e11_busy", 9'(busy), 9'd0);
    xpos = 12'd100; ypos = 12'd100; tick(); vpulse();
    chk("sq_occupied", square_en, 9'h000);

    // 3: click on occupied square is discarded
    click_at(12'd100, 12'd100);
    tick(); chk("occ_e1_busy", 9'(busy), 9'd1);
    tick(); chk("occ_e2_busy", 9'(busy), 9'd0);
    repeat (10) tick();
    chk("occ_board_x", board_x, 9'h001);
    chk("occ_board_o", board_o, 9'h000);
    chk("occ_turn", 9'(turn), 9'd1);
    // click outside the grid is discarded too
    move(12'd2000, 12'd100);
    chk("out_board_o", board_o, 9'h000);
    chk("out_turn", 9'(turn), 9'd1);

    // 4: X wins on the 0-4-8 diagonal
    pulse_ng();
    chk("ng_board_x", board_x, 9'h000);
    chk("ng_turn", 9'(turn), 9'd0);
    move(12'd100, 12'd100);
    move(12'd400, 12'd100);
    move(12'd400, 12'd300);
    move(12'd700, 12'd100);
    chk("pre_win_over", 9'(game_over), 9'd0);
    move(12'd700, 12'd600);
    chk("win_over", 9'(game_over), 9'd1);
    chk("win_winner", 9'(winner), 9'd1);
    chk("win_board_x", board_x, 9'h111);
    chk("win_board_o", board_o, 9'h006);
    chk("win_busy", 9'(busy), 9'd0);
    move(12'd100, 12'd300);
    chk("post_win_board_x", board_x, 9'h111);
    chk("post_win_board_o", board_o, 9'h006);
    chk("post_win_winner", 9'(winner), 9'd1);
    xpos = 12'd100; ypos = 12'd300; tick(); vpulse();
    chk("sq_game_over", square_en, 9'h000);

    // 5: draw
    pulse_ng();
    move(12'd100, 12'd100); move(12'd400, 12'd100);
    move(12'd700, 12'd100); move(12'd400, 12'd300);
    move(12'd100, 12'd300); move(12'd700, 12'd300);
    move(12'd400, 12'd600); move(12'd100, 12'd600);
    chk("draw_pre_turn", 9'(turn), 9'd0);
    chk("draw_pre_over", 9'(game_over), 9'd0);
    move(12'd700, 12'd600);
    chk("draw_board_x", board_x, 9'h18D);
    chk("draw_board_o", board_o, 9'h072);
    chk("draw_winner", 9'(winner), 9'd3);
    chk("draw_over", 9'(game_over), 9'd1);

    // 6a: new_game during EVAL aborts the move
    pulse_ng();
    click_at(12'd400, 12'd300);
    repeat (5) tick();
    chk("abort_mid_board_x", board_x, 9'h010);
    pulse_ng();
    chk("abort_board_x", board_x, 9'h000);
    chk("abort_busy", 9'(busy), 9'd0);
    repeat (12) tick();
    chk("abort_later_turn", 9'(turn), 9'd0);
    chk("abort_later_board_x", board_x, 9'h000);
    // 6b: click coincident with new_game is dropped; new_game blanks highlight at once
    xpos = 12'd700; ypos = 12'd600; tick(); tick(); vpulse();
    chk("sq_before_ng", square_en, 9'h100);
    new_game = 1'b1; mouse_left = 1'b1; #1;
    chk("sq_ng_immediate", square_en, 9'h000);
    tick();
    new_game = 1'b0;
    repeat (3) tick();
    mouse_left = 1'b0;
    tick();
    chk("ng_click_busy", 9'(busy), 9'd0);
    repeat (12) tick();
    chk("ng_click_board_x", board_x, 9'h000);
    // 6c: asynchronous reset during PLACE
    move(12'd100, 12'd100);
    chk("pre_rst_turn", 9'(turn), 9'd1);
    xpos = 12'd700; ypos = 12'd100; tick(); tick(); vpulse();
    click_at(12'd400, 12'd300);
    tick(); tick();
    #2 rst = 1'b0; #1;
    chk("rst_mid_board_x", board_x, 9'h000);
    chk("rst_mid_board_o", board_o, 9'h000);
    chk("rst_mid_turn", 9'(turn), 9'd0);
    chk("rst_mid_busy", 9'(busy), 9'd0);
    chk("rst_mid_sq", square_en, 9'h000);
    tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("rst_after_busy", 9'(busy), 9'd0);
    chk("rst_after_board_o", board_o, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
